temp_sampler: RTL

TEMP_SAMPLER -- requirements
Module: temp_sampler

---
 rtl/temp_pkg.sv | 23 ++
 rtl/temp_sampler_avg.sv | 61 ++++++
 rtl/temp_sampler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/temp_pkg.sv
// Shared definitions for the periodic temperature sampler: FSM state encoding,
// default handshake timeout and accumulator sizing.
package temp_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_REQ    = 3'd2,
        S_ACK    = 3'd3,
        S_CPLT   = 3'd4,
        S_ACCUM  = 3'd5,
        S_UPDATE = 3'd6
    } state_t;

    localparam int TIMEOUT_DEF = 8;
    localparam int ACC_GUARD   = 3;

    // Three guard bits hold the sum of up to eight full-scale samples.
    function automatic int acc_width(input int w);
        return w + ACC_GUARD;
    endfunction

endpackage

// File: rtl/temp_sampler_avg.sv
// Sample averager: accumulates measurements, divides by the batch size
// and flags threshold crossings of the new mean.
module temp_sampler_avg
    import temp_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             lfClk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic             i_upd,
    input  logic [1:0]       i_avg_log2,
    input  logic [WIDTH-1:0] i_sample,
    input  logic [WIDTH-1:0] i_thr_high,
    input  logic [WIDTH-1:0] i_thr_low,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result,
    output logic             o_set_high,
    output logic             o_set_low
);

    localparam int ACC_W = acc_width(WIDTH);

    logic [ACC_W-1:0] r_acc;
    logic [2:0]       r_cnt;
    logic [1:0]       r_avg;
    logic [WIDTH-1:0] r_result;

    logic [3:0]       w_cnt_inc;
    logic [3:0]       w_batch;
    logic [WIDTH-1:0] w_mean;

    assign w_cnt_inc  = {1'b0, r_cnt} + 4'd1;
    assign w_batch    = 4'd1 << r_avg;
    assign o_last     = (w_cnt_inc == w_batch);
    assign w_mean     = WIDTH'(r_acc >> r_avg);
    assign o_set_high = i_upd && (w_mean > i_thr_high);
    assign o_set_low  = i_upd && (w_mean < i_thr_low);
    assign o_result   = r_result;

    // An update also opens the next batch, so continuous sampling never
    // carries old samples forward and re-reads the averaging depth.
    always_ff @(posedge lfClk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_avg    <= '0;
            r_result <= '0;
        end else if (i_clr || i_upd) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_avg <= i_avg_log2;
            if (i_upd) r_result <= w_mean;
        end else if (i_add) begin
            r_acc <= r_acc + ACC_W'(i_sample);
            r_cnt <= r_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/temp_sampler.sv
// Periodic temperature sampler: requests measurements over a start/done
// handshake, averages them and raises sticky threshold and timeout flags.
module temp_sampler
    import temp_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                lfClk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [1:0]          avgLog2,
    input  logic [WIDTH-1:0]    thrHigh,
    input  logic [WIDTH-1:0]    thrLow,
    input  logic                clrAlarm,
    input  logic                done,
    input  logic [WIDTH-1:0]    cycles,
    output logic                start,
    output logic [WIDTH-1:0]    result,
    output logic                resultValid,
    output logic                alarmHigh,
    output logic                alarmLow,
    output logic                timeoutErr,
    output logic                busy
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    state_t r_state, w_next;

    logic [TMR_W-1:0]    r_tmr;
    logic [PERIOD_W-1:0] r_ivl;
    logic [PERIOD_W-1:0] w_ivl_load;
    logic r_start, r_rv, r_ah, r_al, r_te, r_busy;
    logic w_tmo, w_last, w_clr, w_add, w_upd, w_to_set, w_set_high, w_set_low;

    assign w_tmo      = (r_tmr == TMR_W'(TIMEOUT - 1));
    assign w_ivl_load = (period == '0) ? PERIOD_W'(1) : period;

    always_ff @(posedge lfClk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A new request is only issued while the measurement FSM reports idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (enable && done) w_next = S_REQ;
            S_WAIT:   if (r_ivl <= PERIOD_W'(1)) begin
                          if (!enable)  w_next = S_IDLE;
                          else if (done) w_next = S_REQ;
                      end
            S_REQ:    w_next = S_ACK;
            S_ACK:    if (!done)      w_next = S_CPLT;
                      else if (w_tmo) w_next = S_IDLE;
            S_CPLT:   if (done)       w_next = S_ACCUM;
                      else if (w_tmo) w_next = S_IDLE;
            S_ACCUM:  if (w_last)      w_next = S_UPDATE;
                      else if (enable) w_next = S_WAIT;
                      else             w_next = S_IDLE;
            S_UPDATE: w_next = enable ? S_WAIT : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_clr    = (r_state == S_IDLE) && (w_next == S_REQ);
        w_add    = (r_state == S_ACCUM);
        w_upd    = (r_state == S_UPDATE);
        w_to_set = w_tmo && (((r_state == S_ACK) && done) || ((r_state == S_CPLT) && !done));
    end

    always_ff @(posedge lfClk) begin
        if (!rst_n) begin
            r_start <= 1'b0;
            r_rv    <= 1'b0;
            r_ah    <= 1'b0;
            r_al    <= 1'b0;
            r_te    <= 1'b0;
            r_busy  <= 1'b0;
            r_tmr   <= '0;
            r_ivl   <= '0;
        end else begin
            r_start <= (w_next == S_REQ);
            r_rv    <= w_upd;
            r_ah    <= w_set_high | (r_ah & ~clrAlarm);
            r_al    <= w_set_low  | (r_al & ~clrAlarm);
            r_te    <= w_to_set   | (r_te & ~clrAlarm);
            r_busy  <= (w_next != S_IDLE);
            if (w_next != r_state)
                r_tmr <= '0;
            else if (((r_state == S_ACK) || (r_state == S_CPLT)) && !w_tmo)
                r_tmr <= r_tmr + TMR_W'(1);
            if ((w_next == S_WAIT) && (r_state != S_WAIT))
                r_ivl <= w_ivl_load;
            else if ((r_state == S_WAIT) && (r_ivl > PERIOD_W'(1)))
                r_ivl <= r_ivl - PERIOD_W'(1);
        end
    end

    temp_sampler_avg #(.WIDTH(WIDTH)) u_avg (
        .lfClk      (lfClk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_add      (w_add),
        .i_upd      (w_upd),
        .i_avg_log2 (avgLog2),
        .i_sample   (cycles),
        .i_thr_high (thrHigh),
        .i_thr_low  (thrLow),
        .o_last     (w_last),
        .o_result   (result),
        .o_set_high (w_set_high),
        .o_set_low  (w_set_low)
    );

    assign start       = r_start;
    assign resultValid = r_rv;
    assign alarmHigh   = r_ah;
    assign alarmLow    = r_al;
    assign timeoutErr  = r_te;
    assign busy        = r_busy;

endmodule
